// File: rtl/decode_execute_register_if.sv
// Decode-to-execute pipeline bus: decode-side fields and flush in, execute-side
// copies, the fetch/decode freeze and the bubble counter out.
interface decode_execute_register_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);
  logic [15:0]       control_signals_d;
  logic [3:0]        opCode_d;
  logic [REG_W-1:0]  rs1_d;
  logic [REG_W-1:0]  rs2_d;
  logic [REG_W-1:0]  rd_d;
  logic [DATA_W-1:0] src_a_d;
  logic [DATA_W-1:0] src_b_d;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] pc_d;
  logic              valid_d;
  logic              flush;

  logic [15:0]       control_signals_e;
  logic [3:0]        opCode_e;
  logic [REG_W-1:0]  rd_e;
  logic [DATA_W-1:0] src_a_e;
  logic [DATA_W-1:0] src_b_e;
  logic [DATA_W-1:0] imm_e;
  logic [DATA_W-1:0] pc_e;
  logic              valid_e;
  logic              stall_fd;
  logic [15:0]       bubble_count;

  modport master (
    output control_signals_d, opCode_d, rs1_d, rs2_d, rd_d,
           src_a_d, src_b_d, imm_d, pc_d, valid_d, flush,
    input  control_signals_e, opCode_e, rd_e, src_a_e, src_b_e,
           imm_e, pc_e, valid_e, stall_fd, bubble_count
  );

  modport slave (
    input  control_signals_d, opCode_d, rs1_d, rs2_d, rd_d,
           src_a_d, src_b_d, imm_d, pc_d, valid_d, flush,
    output control_signals_e, opCode_e, rd_e, src_a_e, src_b_e,
           imm_e, pc_e, valid_e, stall_fd, bubble_count
  );
endinterface

// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with load-use stall, two-bubble branch
// flush and a saturating count of inserted bubbles.
module decode_execute_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  decode_execute_register_if.slave    bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic [3:0]        op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] src_a_q, src_a_d;
  logic [DATA_W-1:0] src_b_q, src_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              load_use_s;
  logic              bubble_s;
  logic              stall_s;

  // Execute holds a load whose destination the decode instruction reads; r0 never hazards.
  assign load_use_s = (state_q == RUN) && !bus.flush && bus.valid_d && valid_q &&
                      ctrl_q[8] && (rd_q != {REG_W{1'b0}}) &&
                      ((rd_q == bus.rs1_d) || (rd_q == bus.rs2_d));

  // Next-state, bubble and stall decision
  always_comb begin
    state_d  = state_q;
    bubble_s = 1'b0;
    stall_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          bubble_s = 1'b1;
          state_d  = FLUSH;
        end else if (load_use_s) begin
          bubble_s = 1'b1;
          stall_s  = 1'b1;
        end else begin
          bubble_s = 1'b0;
        end
      end
      FLUSH: begin
        bubble_s = 1'b1;
        state_d  = bus.flush ? FLUSH : RUN;
      end
      default: begin
        bubble_s = 1'b1;
        state_d  = RUN;
      end
    endcase
  end

  // Execute-stage payload: a bubble or the decode fields, control zeroed for non-instructions
  always_comb begin
    ctrl_d  = 16'h0000;
    op_d    = 4'h0;
    rd_d    = {REG_W{1'b0}};
    src_a_d = {DATA_W{1'b0}};
    src_b_d = {DATA_W{1'b0}};
    imm_d   = {DATA_W{1'b0}};
    pc_d    = {DATA_W{1'b0}};
    valid_d = 1'b0;
    if (!bubble_s) begin
      ctrl_d  = bus.valid_d ? bus.control_signals_d : 16'h0000;
      op_d    = bus.opCode_d;
      rd_d    = bus.rd_d;
      src_a_d = bus.src_a_d;
      src_b_d = bus.src_b_d;
      imm_d   = bus.imm_d;
      pc_d    = bus.pc_d;
      valid_d = bus.valid_d;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Saturating bubble counter
  always_comb begin
    if (bubble_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline, state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ctrl_q  <= 16'h0000;
      op_q    <= 4'h0;
      rd_q    <= {REG_W{1'b0}};
      src_a_q <= {DATA_W{1'b0}};
      src_b_q <= {DATA_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
      pc_q    <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.control_signals_e = ctrl_q;
  assign bus.opCode_e          = op_q;
  assign bus.rd_e              = rd_q;
  assign bus.src_a_e           = src_a_q;
  assign bus.src_b_e           = src_b_q;
  assign bus.imm_e             = imm_q;
  assign bus.pc_e              = pc_q;
  assign bus.valid_e           = valid_q;
  assign bus.bubble_count      = cnt_q;
  assign bus.stall_fd          = stall_s && !rst;

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 Parameter: DATA_W, 32, width of the operand, immediate and PC fields.
REQ-002 Parameter: REG_W, 4, width of the register-address fields.
REQ-003 Port: clk, in, 1, the single clock; all state updates on the rising edge.
REQ-004 Port: rst, in, 1, asynchronous active-high reset.
REQ-005 Port: control_signals_d, in, 16, decode-stage control bundle:
- [3:0] aluOp
- [5:4] writeback mux select
- [6] write_memory_enable
- [7] wre
- [8] load
- [9] vector_wre
- [15:10] reserved
REQ-006 Port: opCode_d, in, 4, decode-stage opcode.
REQ-007 Port: rs1_d, rs2_d, rd_d, in, REG_W each, source and destination register addresses.
REQ-008 Port: src_a_d, src_b_d, imm_d, pc_d, in, DATA_W each, operands, immediate and PC.
REQ-009 Port: valid_d, in, 1, decode stage holds a real instruction.
REQ-010 Port: flush, in, 1, taken-branch redirect from execute.
REQ-011 Port: control_signals_e, out, 16, registered copy of control_signals_d.
REQ-012 Port: opCode_e, rd_e, src_a_e, src_b_e, imm_e, pc_e, out, registered copies of the matching _d fields.
REQ-013 Port: valid_e, out, 1, execute stage holds a real instruction.
REQ-014 Port: stall_fd, out, 1, combinational; freezes fetch and decode.
REQ-015 Port: bubble_count, out, 16, count of inserted bubbles.

Function
REQ-016 The block SHALL implement a two-state FSM: RUN and FLUSH.
REQ-017 A bubble SHALL load zero into control_signals_e, opCode_e, rd_e and all DATA_W outputs, and load 0 into valid_e.
REQ-018 Load-use hazard, defined as all of:
- state RUN, flush=0
- valid_d=1, valid_e=1, control_signals_e[8]=1
- rd_e != 0
- rd_e == rs1_d or rd_e == rs2_d
REQ-019 On a load-use hazard, stall_fd SHALL be 1 in the same cycle and a bubble SHALL be loaded at the next edge.
REQ-020 A load-use stall SHALL last exactly one cycle; the held instruction SHALL load at the following edge.
REQ-021 In RUN with flush=1, the block SHALL load a bubble, enter FLUSH, and hold stall_fd at 0.
REQ-022 In FLUSH, the block SHALL load a second bubble unconditionally, return to RUN, and hold stall_fd at 0.
REQ-023 flush SHALL take priority over a simultaneous load-use hazard.
REQ-024 flush asserted while in FLUSH SHALL keep the state in FLUSH, giving one more bubble.
REQ-025 In RUN with no hazard and flush=0, all _d fields SHALL load into the _e registers, including valid_d and reserved bits [15:10].
REQ-026 When valid_d=0, control_signals_e SHALL load zero.
REQ-027 bubble_count SHALL increment by 1 per edge at which a bubble is loaded because of a hazard or flush/FLUSH.
REQ-028 Idle cycles with valid_d=0 SHALL NOT increment bubble_count.
REQ-029 bubble_count SHALL saturate at 0xFFFF and not wrap.
REQ-030 Latency from decode to execute SHALL be one cycle when no stall or flush occurs.

Reset
REQ-031 While rst=1, independent of clk, the block SHALL:
- drive every registered output and bubble_count to 0
- set the state to RUN
- drive stall_fd to 0
REQ-032 Reset asserted mid-flush or mid-stall SHALL abort it; the first edge after release SHALL load the _d inputs normally.

Verification
REQ-033 Pass-through: valid_d=1, control_signals_d=0x0081, src_a_d=5, rd_d=3 -> next cycle control_signals_e=0x0081, src_a_e=5, rd_e=3, valid_e=1, stall_fd=0.
REQ-034 Load-use: execute holds ldr (control 0x0181, rd_e=2), decode has rs1_d=2 -> stall_fd=1 for one cycle, bubble loaded, bubble_count=1, dependent instruction in execute one cycle later.
REQ-035 No hazard on r0: same as REQ-034 with rd_e=0 and rs1_d=0 -> stall_fd=0 and no bubble.
REQ-036 Flush: flush=1 for one cycle -> two consecutive bubbles (valid_e=0, control 0x0000), stall_fd=0, bubble_count increases by 2.
REQ-037 Priority and saturation:
- flush together with a load-use hazard -> flush path taken, stall_fd=0
- bubble_count preset to 0xFFFE plus 3 bubbles -> reads 0xFFFF
REQ-038 Reset: rst pulsed asynchronously in the FLUSH state -> all outputs 0 immediately; first post-reset edge loads the decode inputs.
